// File: rtl/frog_pkg.sv
// Shared types and screen geometry for the frog controller and sprite generators.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package frog_pkg;

    typedef enum logic [1:0] {IDLE, HOP, DEAD, OVER} frog_state_t;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;

    localparam int POS_W         = 10;
    localparam int SCREEN_W      = 640;
    localparam int SCREEN_H      = 480;
    localparam int DEF_STEP      = 32;
    localparam int DEF_FROG_SIZE = 32;

endpackage

// File: rtl/frame_tick_counter.sv
// Counts enabled frame ticks and flags the N-th one, then wraps to zero.
// Latency: o_done is combinational on the N-th enabled cycle.
// Backpressure: none; i_clr holds the count at zero.
module frame_tick_counter #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_done
);

    logic [CW-1:0] r_count;

    assign o_done = i_en && (r_count == CW'(N - 1));

    // Count enabled ticks, restarting at zero on clear or once N is reached.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_done ? '0 : r_count + CW'(1);
        end
    end

endmodule

// File: rtl/frog_move_ctrl.sv
// Player frog sequencer: button hops animated over frames, death/respawn, lives, goal scoring.
// Latency: all outputs registered; button to first motion within 2 frame ticks.
// Backpressure: one-deep pending direction, later presses overwrite earlier ones.
module frog_move_ctrl
    import frog_pkg::*;
#(
    parameter int STEP         = DEF_STEP,
    parameter int HOP_FRAMES   = 4,
    parameter int START_X      = 304,
    parameter int START_Y      = 448,
    parameter int MAX_X        = SCREEN_W - DEF_FROG_SIZE,
    parameter int MAX_Y        = SCREEN_H - DEF_FROG_SIZE,
    parameter int GOAL_Y       = 0,
    parameter int LIVES        = 3,
    parameter int DEATH_FRAMES = 60,
    parameter int FROG_SIZE    = DEF_FROG_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             hit,
    output logic [POS_W-1:0] frog_x,
    output logic [POS_W-1:0] frog_y,
    output logic [POS_W-1:0] frog_size,
    output logic             frog_dead,
    output logic [1:0]       lives,
    output logic             game_over,
    output logic             score_pulse
);

    if (STEP % HOP_FRAMES != 0) begin : g_bad_step
        $error("STEP must be divisible by HOP_FRAMES");
    end

    localparam logic [POS_W:0]   P_STEP  = (POS_W+1)'(STEP);
    localparam logic [POS_W:0]   P_MAX_X = (POS_W+1)'(MAX_X);
    localparam logic [POS_W:0]   P_MAX_Y = (POS_W+1)'(MAX_Y);
    localparam logic [POS_W-1:0] P_DELTA = POS_W'(STEP / HOP_FRAMES);
    localparam logic [POS_W-1:0] P_SX    = POS_W'(START_X);
    localparam logic [POS_W-1:0] P_SY    = POS_W'(START_Y);
    localparam logic [POS_W-1:0] P_GOAL  = POS_W'(GOAL_Y);

    frog_state_t      r_state, w_nxt_state;
    dir_t             r_pend_dir, w_nxt_pend_dir, r_hop_dir, w_nxt_hop_dir, w_btn_dir;
    logic             r_pend_vld, w_nxt_pend_vld;
    logic [POS_W-1:0] r_x, r_y, w_nxt_x, w_nxt_y, w_step_x, w_step_y;
    logic [1:0]       r_lives, w_nxt_lives;
    logic             r_dead, r_over, r_score, w_nxt_score;
    logic             w_any_btn, w_in_bounds, w_hop_done, w_death_done;

    assign w_any_btn = btn_up | btn_down | btn_left | btn_right;
    assign w_btn_dir = btn_up ? UP : btn_down ? DOWN : btn_left ? LEFT : RIGHT;

    frame_tick_counter #(.N(HOP_FRAMES)) u_hop_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    ((r_state == HOP) && frame_tick && !hit),
        .i_clr   (r_state != HOP),
        .o_done  (w_hop_done)
    );

    frame_tick_counter #(.N(DEATH_FRAMES)) u_death_cnt (
        .i_clk   (clk),
        .i_reset (reset),
        .i_en    ((r_state == DEAD) && frame_tick),
        .i_clr   (r_state != DEAD),
        .o_done  (w_death_done)
    );

    // Range check of the pending hop, done before any subtraction so nothing wraps.
    always_comb begin
        w_in_bounds = 1'b0;
        case (r_pend_dir)
            UP:    w_in_bounds = {1'b0, r_y} >= P_STEP;
            DOWN:  w_in_bounds = ({1'b0, r_y} + P_STEP) <= P_MAX_Y;
            LEFT:  w_in_bounds = {1'b0, r_x} >= P_STEP;
            RIGHT: w_in_bounds = ({1'b0, r_x} + P_STEP) <= P_MAX_X;
            default: w_in_bounds = 1'b0;
        endcase
    end

    // One animation step toward the target in the latched hop direction.
    always_comb begin
        w_step_x = r_x;
        w_step_y = r_y;
        case (r_hop_dir)
            UP:    w_step_y = r_y - P_DELTA;
            DOWN:  w_step_y = r_y + P_DELTA;
            LEFT:  w_step_x = r_x - P_DELTA;
            RIGHT: w_step_x = r_x + P_DELTA;
            default: ;
        endcase
    end

    // Next-state, pending, position and lives; hit overrides ticks and goal.
    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_pend_vld = r_pend_vld;
        w_nxt_pend_dir = r_pend_dir;
        w_nxt_hop_dir  = r_hop_dir;
        w_nxt_x        = r_x;
        w_nxt_y        = r_y;
        w_nxt_lives    = r_lives;
        w_nxt_score    = 1'b0;
        case (r_state)
            IDLE, HOP: begin
                if (hit) begin
                    w_nxt_state    = DEAD;
                    w_nxt_pend_vld = 1'b0;
                end else begin
                    if (r_state == IDLE && frame_tick && r_pend_vld) begin
                        w_nxt_pend_vld = 1'b0;
                        if (w_in_bounds) begin
                            w_nxt_hop_dir = r_pend_dir;
                            w_nxt_state   = HOP;
                        end
                    end
                    if (r_state == HOP && frame_tick) begin
                        w_nxt_x = w_step_x;
                        w_nxt_y = w_step_y;
                        if (w_hop_done) begin
                            w_nxt_state = IDLE;
                            if (r_hop_dir == UP && w_step_y == P_GOAL) begin
                                w_nxt_score = 1'b1;
                                w_nxt_x     = P_SX;
                                w_nxt_y     = P_SY;
                            end
                        end
                    end
                    if (w_any_btn) begin
                        w_nxt_pend_vld = 1'b1;
                        w_nxt_pend_dir = w_btn_dir;
                    end
                end
            end
            DEAD: begin
                if (w_death_done) begin
                    if (r_lives <= 2'd1) begin
                        w_nxt_lives = 2'd0;
                        w_nxt_state = OVER;
                    end else begin
                        w_nxt_lives = r_lives - 2'd1;
                        w_nxt_x     = P_SX;
                        w_nxt_y     = P_SY;
                        w_nxt_state = IDLE;
                    end
                end
            end
            OVER: begin
                w_nxt_pend_vld = 1'b0;
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // State and output registers; status flags follow the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pend_vld <= 1'b0;
            r_pend_dir <= UP;
            r_hop_dir  <= UP;
            r_x        <= P_SX;
            r_y        <= P_SY;
            r_lives    <= 2'(LIVES);
            r_dead     <= 1'b0;
            r_over     <= 1'b0;
            r_score    <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_pend_vld <= w_nxt_pend_vld;
            r_pend_dir <= w_nxt_pend_dir;
            r_hop_dir  <= w_nxt_hop_dir;
            r_x        <= w_nxt_x;
            r_y        <= w_nxt_y;
            r_lives    <= w_nxt_lives;
            r_dead     <= (w_nxt_state == DEAD);
            r_over     <= (w_nxt_state == OVER);
            r_score    <= w_nxt_score;
        end
    end

    assign frog_x      = r_x;
    assign frog_y      = r_y;
    assign frog_size   = POS_W'(FROG_SIZE);
    assign frog_dead   = r_dead;
    assign lives       = r_lives;
    assign game_over   = r_over;
    assign score_pulse = r_score;

endmodule

// File: tb/tb_frog_move_ctrl.sv
// Directed bench for frog_move_ctrl with hand-computed expectations.
// Latency: n/a.
// Backpressure: n/a.
module tb_frog_move_ctrl;

    logic       clk = 1'b0;
    logic       reset, frame_tick, btn_up, btn_down, btn_left, btn_right, hit;
    logic [9:0] frog_x, frog_y, frog_size;
    logic       frog_dead, game_over, score_pulse;
    logic [1:0] lives;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [3:0] B_NONE = 4'b0000;
    localparam logic [3:0] B_UP   = 4'b1000;
    localparam logic [3:0] B_DN   = 4'b0100;
    localparam logic [3:0] B_LF   = 4'b0010;
    localparam logic [3:0] B_RT   = 4'b0001;

    always #5 clk = ~clk;

    frog_move_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .hit         (hit),
        .frog_x      (frog_x),
        .frog_y      (frog_y),
        .frog_size   (frog_size),
        .frog_dead   (frog_dead),
        .lives       (lives),
        .game_over   (game_over),
        .score_pulse (score_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs, then inputs return low; outputs settle 1ns after the edge.
    task automatic cyc(input logic ft, input logic [3:0] b, input logic h);
        frame_tick = ft;
        {btn_up, btn_down, btn_left, btn_right} = b;
        hit = h;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = B_NONE;
        hit = 1'b0;
    endtask

    task automatic tick();
        cyc(1'b1, B_NONE, 1'b0);
    endtask

    // Press, launch tick, then four animation ticks.
    task automatic hop(input logic [3:0] b);
        cyc(1'b0, b, 1'b0);
        repeat (5) tick();
    endtask

    task automatic die();
        cyc(1'b0, B_NONE, 1'b1);
        repeat (60) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, B_NONE, 1'b0);
        cyc(1'b0, B_NONE, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; hit = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = B_NONE;

        // Reset state
        do_reset();
        chk("rst_x", frog_x, 304);
        chk("rst_y", frog_y, 448);
        chk("rst_size", frog_size, 32);
        chk("rst_lives", lives, 3);
        chk("rst_dead", frog_dead, 0);
        chk("rst_over", game_over, 0);
        chk("rst_score", score_pulse, 0);

        // Up hop animates 8 px per tick
        cyc(1'b0, B_UP, 1'b0);
        tick(); chk("launch_y", frog_y, 448);
        tick(); chk("hop1_y", frog_y, 440);
        tick(); chk("hop2_y", frog_y, 432);
        tick(); chk("hop3_y", frog_y, 424);
        tick(); chk("hop4_y", frog_y, 416);
        tick(); chk("idle_y", frog_y, 416);
        chk("idle_x", frog_x, 304);

        // Bottom edge: down hop dropped
        do_reset();
        cyc(1'b0, B_DN, 1'b0); tick(); tick();
        chk("down_edge_y", frog_y, 448);
        // Walk left to x=16, then a further left hop is dropped (no wrap)
        repeat (9) hop(B_LF);
        chk("left_walk_x", frog_x, 16);
        hop(B_LF);
        chk("left_edge_x", frog_x, 16);
        // Walk right to x=592, further right would exceed 608
        do_reset();
        repeat (9) hop(B_RT);
        chk("right_walk_x", frog_x, 592);
        hop(B_RT);
        chk("right_edge_x", frog_x, 592);

        // Simultaneous up+right: up wins; left buffered during hop
        do_reset();
        cyc(1'b0, B_UP | B_RT, 1'b0);
        tick(); tick();
        chk("prio_y", frog_y, 440);
        chk("prio_x", frog_x, 304);
        cyc(1'b0, B_LF, 1'b0);
        repeat (3) tick();
        chk("buf_end_y", frog_y, 416);
        chk("buf_end_x", frog_x, 304);
        tick(); chk("buf_launch_x", frog_x, 304);
        tick(); chk("buf_step_x", frog_x, 296);
        repeat (3) tick();
        chk("buf_done_x", frog_x, 272);

        // Hit mid-hop freezes position, respawn after 60 ticks
        do_reset();
        cyc(1'b0, B_UP, 1'b0);
        tick(); tick(); tick();
        cyc(1'b0, B_NONE, 1'b1);
        chk("hit_dead", frog_dead, 1);
        chk("hit_y", frog_y, 432);
        cyc(1'b0, B_UP, 1'b0);
        repeat (59) tick();
        chk("dead59_lives", lives, 3);
        chk("dead59_dead", frog_dead, 1);
        tick();
        chk("respawn_lives", lives, 2);
        chk("respawn_dead", frog_dead, 0);
        chk("respawn_x", frog_x, 304);
        chk("respawn_y", frog_y, 448);
        tick(); tick();
        chk("no_dead_press_y", frog_y, 448);

        // Remaining lives lost -> game over, inputs ignored
        die();
        chk("lives1", lives, 1);
        die();
        chk("over_lives", lives, 0);
        chk("over_flag", game_over, 1);
        chk("over_dead", frog_dead, 0);
        cyc(1'b0, B_UP, 1'b1);
        tick(); tick();
        chk("over_hold", game_over, 1);
        chk("over_y", frog_y, 448);
        chk("over_lives2", lives, 0);
        do_reset();
        chk("rst2_lives", lives, 3);
        chk("rst2_over", game_over, 0);

        // Goal reached: one score pulse, respawn, lives kept
        repeat (13) hop(B_UP);
        chk("goal_pre_y", frog_y, 32);
        cyc(1'b0, B_UP, 1'b0);
        repeat (4) tick();
        chk("goal_near_y", frog_y, 8);
        tick();
        chk("goal_score", score_pulse, 1);
        chk("goal_y", frog_y, 448);
        chk("goal_x", frog_x, 304);
        chk("goal_lives", lives, 3);
        cyc(1'b0, B_NONE, 1'b0);
        chk("goal_score_off", score_pulse, 0);

        // Hit on the goal tick: death wins, no score
        repeat (13) hop(B_UP);
        cyc(1'b0, B_UP, 1'b0);
        repeat (4) tick();
        cyc(1'b1, B_NONE, 1'b1);
        chk("goalhit_dead", frog_dead, 1);
        chk("goalhit_score", score_pulse, 0);
        chk("goalhit_y", frog_y, 8);
        cyc(1'b0, B_NONE, 1'b0);
        chk("goalhit_score2", score_pulse, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
